// File: rtl/button_pkg.sv
// Shared constants and event type for the push-button front end.
package button_pkg;

  localparam int unsigned BTN_SYNC_STAGES     = 2;
  localparam int unsigned BTN_DEBOUNCE_CYCLES = 4;
  localparam int unsigned BTN_HOLD_CYCLES     = 1000;
  localparam int unsigned BTN_REPEAT_CYCLES   = 250;

  // One-cycle event pair as seen by consumers of a detector.
  typedef struct packed {
    logic press;
    logic release_pulse;
  } btn_evt_t;

  // Auto-repeat sequencer states.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_press_detector_if.sv
// Button-side signal bundle: raw level in, clean press/release/level out.
interface button_press_detector_if;

  logic btn_in;
  logic press;
  logic release_pulse;
  logic level;

  modport master (output btn_in, input press, input release_pulse, input level);
  modport slave  (input btn_in, output press, output release_pulse, output level);

endinterface

// File: rtl/btn_sync.sv
// Flop chain bringing the asynchronous button level into the clk domain.
module btn_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the sampled level down the chain; reset clears to released.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/button_press_detector.sv
// Debounces one bouncing push-button and emits single-cycle press/release pulses.
// Optional auto-repeat on long holds: define BUTTON_PRESS_DETECTOR_AUTOREPEAT_EN.
module button_press_detector
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = BTN_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
  parameter int unsigned ACTIVE_LOW      = 0,
  parameter int unsigned HOLD_CYCLES     = BTN_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = BTN_REPEAT_CYCLES
) (
  input logic                     clk,
  input logic                     rst,
  button_press_detector_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the logic below cannot honour.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("button_press_detector: invalid parameter value");
  end

  logic             btn_pol;
  logic             sync;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             accept_c;
  logic             repeat_c;
  btn_evt_t         evt_q;
  btn_evt_t         evt_d;

  // Polarity is fixed before synchronizing so everything downstream is active-high.
  assign btn_pol = (ACTIVE_LOW != 0) ? ~bus.btn_in : bus.btn_in;

  btn_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_pol),
    .q   (sync)
  );

  // Debounce: count consecutive disagreeing cycles, accept on the last one.
  always_comb begin
    cnt_d    = '0;
    level_d  = level_q;
    accept_c = 1'b0;
    if (sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        accept_c = 1'b1;
        level_d  = sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef BUTTON_PRESS_DETECTOR_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [RPT_W-1:0] HOLD_LAST   = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] REPEAT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  rpt_state_t       rpt_q;
  rpt_state_t       rpt_d;
  logic [RPT_W-1:0] rcnt_q;
  logic [RPT_W-1:0] rcnt_d;

  // Auto-repeat state and interval counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q  <= RPT_IDLE;
      rcnt_q <= '0;
    end else begin
      rpt_q  <= rpt_d;
      rcnt_q <= rcnt_d;
    end
  end

  // Auto-repeat sequencing: initial delay after the press, then fixed period; a release aborts.
  always_comb begin
    rpt_d    = rpt_q;
    rcnt_d   = rcnt_q;
    repeat_c = 1'b0;
    case (rpt_q)
      RPT_IDLE: begin
        rcnt_d = '0;
        if (accept_c && level_d) begin
          rpt_d = RPT_HOLD;
        end
      end
      RPT_HOLD: begin
        if (accept_c) begin
          rpt_d  = RPT_IDLE;
          rcnt_d = '0;
        end else if (rcnt_q == HOLD_LAST) begin
          repeat_c = 1'b1;
          rcnt_d   = '0;
          rpt_d    = RPT_REPEAT;
        end else begin
          rcnt_d = rcnt_q + RPT_W'(1);
        end
      end
      RPT_REPEAT: begin
        if (accept_c) begin
          rpt_d  = RPT_IDLE;
          rcnt_d = '0;
        end else if (rcnt_q == REPEAT_LAST) begin
          repeat_c = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RPT_W'(1);
        end
      end
      default: begin
        rpt_d  = RPT_IDLE;
        rcnt_d = '0;
      end
    endcase
  end
`else
  assign repeat_c = 1'b0;
`endif

  // Edge pulses land on the same edge that updates the stable level.
  always_comb begin
    evt_d               = '0;
    evt_d.press         = (accept_c && sync) || repeat_c;
    evt_d.release_pulse = accept_c && !sync;
  end

  // Debounce and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.press         = evt_q.press;
  assign bus.release_pulse = evt_q.release_pulse;
  assign bus.level         = level_q;

endmodule

// File: tb/tb_button_press_detector.sv
// Self-checking bench for button_press_detector against a window-based reference model.
module tb_button_press_detector;

  localparam int S    = 2;
  localparam int D    = 4;
  localparam int HOLD = 20;
  localparam int RPT  = 5;
  localparam int LAT  = S + D;

  logic clk = 1'b0;
  logic rst;

  button_press_detector_if bus ();

  button_press_detector #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (0),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef BUTTON_PRESS_DETECTOR_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  // Reference model: level flips when the synchronized input has disagreed
  // with it on each of the last D edges since the most recent reset.
  logic q_samp[$];
  logic q_rst[$];
  logic q_sync[$];
  int   last_rst = -1;
  int   t0       = 0;
  logic m_level  = 1'b0;
  logic m_press  = 1'b0;
  logic m_rel    = 1'b0;

  always @(posedge clk) begin
    int   n;
    logic sv;
    bit   all_diff;
    q_rst.push_back(rst);
    q_samp.push_back(rst ? 1'b0 : bus.btn_in);
    n  = q_rst.size() - 1;
    sv = 1'b0;
    if (n >= S) begin
      sv = q_samp[n - S];
      for (int k = n - S; k < n; k++) if (q_rst[k]) sv = 1'b0;
    end
    q_sync.push_back(sv);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (rst) begin
      last_rst = n;
      m_level  = 1'b0;
    end else begin
      all_diff = (n - D + 1 > last_rst) && (n - D + 1 >= 0);
      if (all_diff) for (int k = n - D + 1; k <= n; k++) if (q_sync[k] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        m_press = m_level;
        m_rel   = ~m_level;
        if (m_level) t0 = n;
      end else if (AUTOREP && m_level && (n - t0 >= HOLD) && ((n - t0 - HOLD) % RPT == 0)) begin
        m_press = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int first = -1;
    rst = 1'b1;
    bus.btn_in = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if ({bus.press, bus.release_pulse, bus.level} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs got %b exp 000", {bus.press, bus.release_pulse, bus.level});
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({bus.press, bus.release_pulse, bus.level} !== {m_press, m_rel, m_level}) begin
        errors++;
        $display("FAIL reset_model cycle %0d got %b exp %b", i, {bus.press, bus.release_pulse, bus.level}, {m_press, m_rel, m_level});
      end
      if (bus.press === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first != LAT) begin
      errors++;
      $display("FAIL reset_press_latency got %0d exp %0d", first, LAT);
    end
    checks++;
    if (bus.level !== 1'b1) begin
      errors++;
      $display("FAIL reset_level got %b exp 1", bus.level);
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int npress = 0;
    int exp_n = AUTOREP ? 6 : 1;
    rst = 1'b0;
    bus.btn_in = 1'b0;
    repeat (12) tick();
    bus.btn_in = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      checks++;
      if ({bus.press, bus.release_pulse, bus.level} !== {m_press, m_rel, m_level}) begin
        errors++;
        $display("FAIL clean_model cycle %0d got %b exp %b", i, {bus.press, bus.release_pulse, bus.level}, {m_press, m_rel, m_level});
      end
      if (bus.press === 1'b1) begin
        npress++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first != LAT) begin
      errors++;
      $display("FAIL clean_latency got %0d exp %0d", first, LAT);
    end
    checks++;
    if (npress != exp_n) begin
      errors++;
      $display("FAIL clean_press_count got %0d exp %0d", npress, exp_n);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat = 8'b00110011;
    int first = -1;
    int early = 0;
    bus.btn_in = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < 8; i++) begin
      bus.btn_in = pat[i];
      tick();
      if (bus.press === 1'b1 || bus.release_pulse === 1'b1) early++;
    end
    bus.btn_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({bus.press, bus.release_pulse, bus.level} !== {m_press, m_rel, m_level}) begin
        errors++;
        $display("FAIL bounce_model cycle %0d got %b exp %b", i, {bus.press, bus.release_pulse, bus.level}, {m_press, m_rel, m_level});
      end
      if (bus.press === 1'b1) begin
        if (first < 0) first = i;
        else early++;
      end
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL bounce_extra_pulses got %0d exp 0", early);
    end
    checks++;
    if (first != LAT) begin
      errors++;
      $display("FAIL bounce_latency got %0d exp %0d", first, LAT);
    end
  endtask

  task automatic test_release();
    int first = -1;
    int npress = 0;
    bus.btn_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({bus.press, bus.release_pulse, bus.level} !== {m_press, m_rel, m_level}) begin
        errors++;
        $display("FAIL release_model cycle %0d got %b exp %b", i, {bus.press, bus.release_pulse, bus.level}, {m_press, m_rel, m_level});
      end
      if (bus.release_pulse === 1'b1 && first < 0) first = i;
      if (bus.press === 1'b1) npress++;
    end
    checks++;
    if (first != LAT) begin
      errors++;
      $display("FAIL release_latency got %0d exp %0d", first, LAT);
    end
    checks++;
    if (npress != 0 || bus.level !== 1'b0) begin
      errors++;
      $display("FAIL release_state got press_count=%0d level=%b exp 0 0", npress, bus.level);
    end
  endtask

  task automatic test_mid_reset();
    int first = -1;
    int early = 0;
    bus.btn_in = 1'b1;
    repeat (4) begin
      tick();
      if (bus.press === 1'b1) early++;
    end
    rst = 1'b1;
    tick();
    if (bus.press === 1'b1 || bus.level === 1'b1) early++;
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({bus.press, bus.release_pulse, bus.level} !== {m_press, m_rel, m_level}) begin
        errors++;
        $display("FAIL midrst_model cycle %0d got %b exp %b", i, {bus.press, bus.release_pulse, bus.level}, {m_press, m_rel, m_level});
      end
      if (bus.press === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL midrst_early_press got %0d exp 0", early);
    end
    checks++;
    if (first != LAT) begin
      errors++;
      $display("FAIL midrst_latency got %0d exp %0d", first, LAT);
    end
  endtask

  task automatic test_random();
    int left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (left == 0) begin
        bus.btn_in = 1'($urandom_range(0, 1));
        left = $urandom_range(1, 10);
      end
      left--;
      rst = ($urandom_range(0, 59) == 0);
      tick();
      checks++;
      if ({bus.press, bus.release_pulse, bus.level} !== {m_press, m_rel, m_level}) begin
        errors++;
        $display("FAIL random_model cycle %0d got %b exp %b", i, {bus.press, bus.release_pulse, bus.level}, {m_press, m_rel, m_level});
      end
      checks++;
      if (bus.press === 1'b1 && bus.release_pulse === 1'b1) begin
        errors++;
        $display("FAIL random_exclusive cycle %0d got press=1 release=1 exp not both", i);
      end
    end
    rst = 1'b0;
  endtask

`ifdef BUTTON_PRESS_DETECTOR_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int pulses[$];
    int first = -1;
    bus.btn_in = 1'b0;
    repeat (12) tick();
    for (int i = 1; i <= 70; i++) begin
      bus.btn_in = (i <= 40);
      tick();
      checks++;
      if ({bus.press, bus.release_pulse, bus.level} !== {m_press, m_rel, m_level}) begin
        errors++;
        $display("FAIL autorep_model cycle %0d got %b exp %b", i, {bus.press, bus.release_pulse, bus.level}, {m_press, m_rel, m_level});
      end
      if (bus.press === 1'b1) begin
        if (first < 0) first = i;
        pulses.push_back(i - first);
      end
    end
    checks++;
    if (pulses.size() != 5) begin
      errors++;
      $display("FAIL autorep_count got %0d exp 5", pulses.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        int exp_off = (k == 0) ? 0 : HOLD + (k - 1) * RPT;
        checks++;
        if (pulses[k] != exp_off) begin
          errors++;
          $display("FAIL autorep_offset idx %0d got %0d exp %0d", k, pulses[k], exp_off);
        end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.btn_in = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_mid_reset();
    test_random();
`ifdef BUTTON_PRESS_DETECTOR_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
